// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage between the PC and decode.
// Issues word reads to instruction memory and tags each read with its aligned PC.
// Returned instructions are kept in a small in-order queue that feeds decode.
// A redirect (flush) empties the queue and marks every in-flight read for discard.
//
// Handshakes:
//   PC side:     a request transfers in any cycle where pc_valid && pc_ready.
//                That same cycle, the read strobe (imem_req) is raised.
//   Decode side: the head entry transfers in any cycle where instr_valid && instr_ready.
//                instr and instr_pc stay stable while instr_valid is high and instr_ready is low.
//   Memory side: every strobe is accepted; each imem_rvalid answers the oldest open read.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int QW = $clog2(DEPTH);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = QW + 1;

  // Instruction queue storage and pointers
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [QW-1:0]     q_wr;
  logic [QW-1:0]     q_rd;

  // Occupancy, outstanding reads, reads still owed a discard
  logic [CW-1:0]     count;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     disc;

  // Tag FIFO: one aligned PC per outstanding read
  logic [ADDR_W-1:0] tag_mem [MAX_OUT];
  logic [TW-1:0]     tag_wr;
  logic [TW-1:0]     tag_rd;

  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_sum;
  logic [ADDR_W-1:0] aligned_pc;

  // Credits, issue, response and pop decisions
  always_comb begin
    credit_sum = {1'b0, count} + {1'b0, out_cnt};
    aligned_pc = pc_in & ~(ADDR_W'(3));
    pc_ready   = rst_n && !flush
                 && (out_cnt < CW'(MAX_OUT))
                 && (credit_sum < (CW+1)'(DEPTH));
    issue      = pc_valid && pc_ready;
    // A response with no read open is a protocol error and is ignored
    resp       = imem_rvalid && (out_cnt != '0);
    push       = resp && !flush && (disc == '0);
    pop        = instr_valid && instr_ready && !flush;
  end

  assign imem_req    = issue;
  assign imem_addr   = aligned_pc;
  assign instr_valid = (count != '0);
  assign instr       = q_data[q_rd];
  assign instr_pc    = q_pc[q_rd];

  // Counters and queue pointers; flush resets the queue and converts in-flight reads to discards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      out_cnt <= '0;
      disc    <= '0;
      q_wr    <= '0;
      q_rd    <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(issue) - CW'(resp);
      if (flush) begin
        disc  <= out_cnt - CW'(resp);
        count <= '0;
        q_wr  <= '0;
        q_rd  <= '0;
      end else begin
        if (resp && (disc != '0)) disc <= disc - 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (push) q_wr <= q_wr + 1'b1;
        if (pop)  q_rd <= q_rd + 1'b1;
      end
    end
  end

  // Tag FIFO pointers: push on issue, pop on every accepted response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (issue) tag_wr <= (MAX_OUT == 1) ? '0 : tag_wr + 1'b1;
      if (resp)  tag_rd <= (MAX_OUT == 1) ? '0 : tag_rd + 1'b1;
    end
  end

  // Tag FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) tag_mem[i] <= '0;
    end else if (issue) begin
      tag_mem[tag_wr] <= aligned_pc;
    end
  end

  // Queue storage: the response data is written together with the tag of its read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (push) begin
      q_data[q_wr] <= imem_rdata;
      q_pc[q_wr]   <= tag_mem[tag_rd];
    end
  end

endmodule
